ws281x_pixel_decoder: RTL and testbench
=======================================

# ws281x_pixel_decoder

Receives the raw single-wire WS281X serial stream, measures each high pulse against cycle thresholds, decodes bits, and assembles 24-bit pixels MSB-first. Detects the low-time latch gap that ends a frame. Sits directly downstream of the input pin and upstream of the splitter's channel-routing counters, which consume `PixelValid`, `PixelIndex` and `FrameEnd`.

## Interface
- `CNT_WIDTH`, 12: width of the pulse-width counters; saturate at all-ones.
- `T_THRESH`, 30: high-time cycles at or above which a bit decodes as 1 (50 MHz: 0-bit ≈20, 1-bit ≈40).
- `T_HIGH_MAX`, 100: high-time cycles above which the pulse is an error.
- `T_LATCH`, 2500: low-time cycles that constitute a latch gap (50 µs at 50 MHz).
- `IDX_WIDTH`, 10: width of the pixel index.

Ports:
- `Clock` in 1: the block's only clock; all flops on its rising edge.
- `Reset` in 1: synchronous, active-low (0 = reset), sampled on `Clock`.
- `Din` in 1: raw asynchronous WS281X data.
- `Pixel` out 24: last completed pixel, bits in arrival order.
- `PixelValid` out 1: one-cycle strobe when `Pixel` updates.
- `PixelIndex` out IDX_WIDTH: 0-based index of the pixel on `Pixel` within the current frame.
- `FrameEnd` out 1: one-cycle strobe on latch-gap detection.
- `Error` out 1: sticky protocol error; cleared only by the next latch gap or reset.

## Operation
- `Din` passes through a 2-flop synchronizer. The output is `DinS`, and `DinD` is `DinS` delayed one cycle. Rise is `DinS & ~DinD`; fall is `~DinS & DinD`.
- `HighCnt` counts cycles with `DinS`=1 and clears on rise. `LowCnt` counts cycles with `DinS`=0 and clears on fall. Both counters saturate.
- States:
  - WAIT_GAP: entered on reset. Ignores data. Moves to IDLE when `LowCnt` reaches `T_LATCH`. No `FrameEnd` is issued for this first gap.
  - IDLE: armed, line low. On rise, go to HIGH.
  - HIGH: on fall, decode bit = (`HighCnt` ≥ `T_THRESH`), shift it into the 24-bit shift register, increment `BitCnt` (0..23), and go to LOW. If `HighCnt` exceeds `T_HIGH_MAX` while still high, set `Error`, discard the partial pixel, and go to WAIT_GAP.
  - LOW: on rise, go to HIGH. If `LowCnt` reaches `T_LATCH`, pulse `FrameEnd`, discard the partial pixel (`BitCnt`←0), clear `Error`, set next index to 0, and go to IDLE.
- When the 24th bit is decoded:
  - `Pixel` ← shift register contents including the new bit.
  - `PixelValid` pulses.
  - `PixelIndex` ← running count, and the running count increments.
  - `BitCnt` ← 0.
- The running pixel count saturates at all-ones. Further pixels reuse the saturated index.
- `FrameEnd` also fires from IDLE after a completed pixel, since the gap timing is identical.
- `FrameEnd` does not fire while in WAIT_GAP, so an error recovery does not produce a spurious frame end.

## Timing
- Reset values: `Pixel`=0, `PixelValid`=0, `PixelIndex`=0, `FrameEnd`=0, `Error`=0; state WAIT_GAP; all counters 0.
- Latency: `PixelValid` is asserted on the 3rd rising `Clock` edge after the first edge that samples `Din`=0 at the end of the 24th bit (2 synchronizer cycles plus 1 registered decode).
- `FrameEnd` is asserted 3 cycles after the `T_LATCH`-th consecutive low sample.
- `Error` sets in the cycle `HighCnt` becomes `T_HIGH_MAX`+1.
- Pulses shorter than 1 cycle may be lost. This is acceptable.
- If the 24th bit's fall and a latch condition could coincide, the pixel wins. A latch needs ≥ `T_LATCH` low cycles after the fall, so they never share a cycle.
- Reset mid-pixel discards all state. The following gap is required before any decode.
- Outputs are registered, with no combinational path from `Din`.

## Structure
- Package `ws281x_pkg`:
  - state enum (WAIT_GAP, IDLE, HIGH, LOW);
  - default timing constants for 50 MHz;
  - `PIXEL_BITS`=24.
- Sub-module `ws281x_din_sync`: 2-flop synchronizer plus rise/fall detect, with `Clock`/`Reset` ports identical to the parent.
- The rest is the FSM, the two saturating counters, the shift register and the index counter. All of it stays in the top level.

## Test plan
1. Reset, hold `Din`=0 for 2500 cycles, then send 24 bits of 0xA5C30F (high 40/20, low 20/40) → one `PixelValid`, `Pixel`=0xA5C30F, `PixelIndex`=0.
2. Three pixels 0x000001, 0xFFFFFF, 0x800000, then 2500 low cycles → indices 0,1,2, followed by one `FrameEnd`. The next frame's first pixel has `PixelIndex`=0.
3. Boundary widths: high of exactly 29 cycles decodes 0 and 30 decodes 1. Low of 2499 cycles gives no `FrameEnd`; 2500 gives `FrameEnd`.
4. High held for 101 cycles mid-pixel → `Error`=1 and no `PixelValid`. After a 2500-cycle gap, `Error`=0 and no `FrameEnd`; the next pixel decodes correctly.
5. 12 bits sent, then a latch gap → no `PixelValid` and one `FrameEnd`. The following 24 bits yield the correct pixel at index 0.
6. Assert `Reset`=0 for 1 cycle after bit 10 → all outputs 0. Data before the next 2500-cycle gap is ignored.

Source files
------------

// File: rtl/ws281x_pixel_decoder_pkg.sv
// Shared types and 50 MHz timing defaults for the WS281X pixel decoder.
package ws281x_pkg;

  localparam int unsigned PIXEL_BITS     = 24;
  localparam int unsigned BIT_CNT_WIDTH  = 5;
  localparam int unsigned CNT_WIDTH_DEF  = 12;
  localparam int unsigned T_THRESH_DEF   = 30;
  localparam int unsigned T_HIGH_MAX_DEF = 100;
  localparam int unsigned T_LATCH_DEF    = 2500;
  localparam int unsigned IDX_WIDTH_DEF  = 10;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2,
    LOW      = 2'd3
  } state_t;

endpackage

// File: rtl/ws281x_pixel_decoder_if.sv
// Serial input and decoded-pixel outputs of the WS281X decoder.
interface ws281x_pixel_decoder_if #(
  parameter int unsigned IDX_WIDTH = ws281x_pkg::IDX_WIDTH_DEF
) ();

  logic                   Din;
  ws281x_pkg::pixel_t     Pixel;
  logic                   PixelValid;
  logic [IDX_WIDTH-1:0]   PixelIndex;
  logic                   FrameEnd;
  logic                   Error;

  modport master (
    output Din,
    input  Pixel, PixelValid, PixelIndex, FrameEnd, Error
  );

  modport slave (
    input  Din,
    output Pixel, PixelValid, PixelIndex, FrameEnd, Error
  );

endinterface

// File: rtl/ws281x_pixel_decoder_din_sync.sv
// Two-flop synchronizer for the raw data pin plus edge detection on the
// synchronized level.
module ws281x_din_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic Din,
  output logic DinS,
  output logic Rise_c,
  output logic Fall_c
);

  logic Meta;
  logic DinD;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Meta <= 1'b0;
      DinS <= 1'b0;
      DinD <= 1'b0;
    end else begin
      Meta <= Din;
      DinS <= Meta;
      DinD <= DinS;
    end
  end

  assign Rise_c = DinS & ~DinD;
  assign Fall_c = ~DinS & DinD;

endmodule

// File: rtl/ws281x_pixel_decoder.sv
// WS281X single-wire decoder: measures high pulses, assembles 24-bit pixels
// MSB-first, and flags latch gaps and over-long highs.
module ws281x_pixel_decoder
  import ws281x_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned T_THRESH   = T_THRESH_DEF,
  parameter int unsigned T_HIGH_MAX = T_HIGH_MAX_DEF,
  parameter int unsigned T_LATCH    = T_LATCH_DEF,
  parameter int unsigned IDX_WIDTH  = IDX_WIDTH_DEF
) (
  input logic                   Clock,
  input logic                   Reset,
  ws281x_pixel_decoder_if.slave Bus
);

  localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]     THRESH   = CNT_WIDTH'(T_THRESH);
  localparam logic [CNT_WIDTH-1:0]     HIGH_MAX = CNT_WIDTH'(T_HIGH_MAX);
  localparam logic [CNT_WIDTH-1:0]     LATCH    = CNT_WIDTH'(T_LATCH);
  localparam logic [IDX_WIDTH-1:0]     IDX_MAX  = '1;
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(PIXEL_BITS - 1);

  logic DinS;
  logic Rise_c;
  logic Fall_c;

  ws281x_din_sync u_din_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .Din    (Bus.Din),
    .DinS   (DinS),
    .Rise_c (Rise_c),
    .Fall_c (Fall_c)
  );

  state_t                   State;
  state_t                   StateNxt;
  logic [CNT_WIDTH-1:0]     HighCnt;
  logic [CNT_WIDTH-1:0]     LowCnt;
  logic [BIT_CNT_WIDTH-1:0] BitCnt;
  logic [IDX_WIDTH-1:0]     RunCnt;
  // Only 23 bits are held; the 24th arrives straight into Pixel.
  logic [PIXEL_BITS-2:0]    ShiftReg;

  pixel_t                   Pixel;
  logic                     PixelValid;
  logic [IDX_WIDTH-1:0]     PixelIndex;
  logic                     FrameEnd;
  logic                     Error;

  logic   latch_hit;
  logic   gap_seen;
  logic   gap_exit;
  logic   high_over;
  logic   bit_val;
  logic   last_bit;
  pixel_t shift_nxt;

  logic do_shift;
  logic do_clear;
  logic do_frame_end;
  logic set_error;
  logic clr_error;

  // A gap is exact-hit for frame end; WAIT_GAP accepts any long-enough low,
  // but not a stale count left over from before an error's long high.
  assign latch_hit = (LowCnt == LATCH);
  assign gap_seen  = (LowCnt >= LATCH);
  assign gap_exit  = gap_seen && (!DinS || Rise_c);
  assign high_over = DinS && (HighCnt >= HIGH_MAX);
  assign bit_val   = (HighCnt >= THRESH);
  assign last_bit  = (BitCnt == LAST_BIT);
  assign shift_nxt = {ShiftReg, bit_val};

  // Saturating pulse-width counters; the first cycle of a level counts as 1.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      HighCnt <= '0;
      LowCnt  <= '0;
    end else if (DinS) begin
      if (Rise_c)                HighCnt <= CNT_WIDTH'(1);
      else if (HighCnt != CNT_MAX) HighCnt <= HighCnt + CNT_WIDTH'(1);
    end else begin
      if (Fall_c)                LowCnt <= CNT_WIDTH'(1);
      else if (LowCnt != CNT_MAX)  LowCnt <= LowCnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) State <= WAIT_GAP;
    else        State <= StateNxt;
  end

  always_comb begin
    StateNxt = State;
    case (State)
      WAIT_GAP: if (gap_exit) StateNxt = Rise_c ? HIGH : IDLE;
      IDLE:     if (Rise_c)   StateNxt = HIGH;
      HIGH: begin
        if (Fall_c)         StateNxt = LOW;
        else if (high_over) StateNxt = WAIT_GAP;
      end
      LOW: begin
        if (Rise_c)         StateNxt = HIGH;
        else if (latch_hit) StateNxt = IDLE;
      end
      default: StateNxt = WAIT_GAP;
    endcase
  end

  // Datapath controls; a latch coinciding with a rise still ends the frame.
  always_comb begin
    do_shift     = 1'b0;
    do_clear     = 1'b0;
    do_frame_end = 1'b0;
    set_error    = 1'b0;
    clr_error    = 1'b0;
    case (State)
      WAIT_GAP: begin
        if (gap_exit) begin
          do_clear  = 1'b1;
          clr_error = 1'b1;
        end
      end
      IDLE: begin
        if (latch_hit && (RunCnt != '0)) begin
          do_frame_end = 1'b1;
          do_clear     = 1'b1;
          clr_error    = 1'b1;
        end
      end
      HIGH: begin
        if (Fall_c) begin
          do_shift = 1'b1;
        end else if (high_over) begin
          set_error = 1'b1;
          do_clear  = 1'b1;
        end
      end
      LOW: begin
        if (latch_hit) begin
          do_frame_end = 1'b1;
          do_clear     = 1'b1;
          clr_error    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      BitCnt     <= '0;
      RunCnt     <= '0;
      ShiftReg   <= '0;
      Pixel      <= '0;
      PixelValid <= 1'b0;
      PixelIndex <= '0;
      FrameEnd   <= 1'b0;
      Error      <= 1'b0;
    end else begin
      PixelValid <= do_shift && last_bit;
      FrameEnd   <= do_frame_end;

      if (set_error)      Error <= 1'b1;
      else if (clr_error) Error <= 1'b0;

      if (do_clear) begin
        BitCnt <= '0;
        RunCnt <= '0;
      end else if (do_shift) begin
        ShiftReg <= shift_nxt[PIXEL_BITS-2:0];
        if (last_bit) begin
          BitCnt     <= '0;
          Pixel      <= shift_nxt;
          PixelIndex <= RunCnt;
          if (RunCnt != IDX_MAX) RunCnt <= RunCnt + IDX_WIDTH'(1);
        end else begin
          BitCnt <= BitCnt + BIT_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign Bus.Pixel      = Pixel;
  assign Bus.PixelValid = PixelValid;
  assign Bus.PixelIndex = PixelIndex;
  assign Bus.FrameEnd   = FrameEnd;
  assign Bus.Error      = Error;

endmodule

// File: tb/tb_ws281x_pixel_decoder.sv
// Scoreboard bench for ws281x_pixel_decoder: pixels are queued when sent and
// matched when PixelValid strobes; frame-end and error behaviour is spot-checked.
module tb_ws281x_pixel_decoder;

  localparam int unsigned IDX_W = 10;

  logic Clock = 1'b0;
  logic Reset;

  ws281x_pixel_decoder_if #(.IDX_WIDTH(IDX_W)) bus ();

  ws281x_pixel_decoder dut (
    .Clock (Clock),
    .Reset (Reset),
    .Bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [23:0]      pix;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   fe_count    = 0;
  int   pv_count    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pop the scoreboard on every pixel strobe.
  always @(negedge Clock) begin
    exp_t e;
    if (Reset === 1'b1) begin
      if (bus.FrameEnd === 1'b1) fe_count++;
      if (bus.PixelValid === 1'b1) begin
        pv_count++;
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(bus.PixelValid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("pixel", 32'(bus.Pixel), 32'(e.pix));
          check("index", 32'(bus.PixelIndex), 32'(e.idx));
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    bus.Din = v;
    repeat (n) @(negedge Clock);
  endtask

  // Send the low nbits of v MSB-first; the final bit's low lasts lo_gap cycles.
  task automatic send_word(input logic [23:0] v, input int nbits, input int hi0,
                           input int hi1, input int lo_gap);
    for (int i = nbits - 1; i >= 0; i--) begin
      logic b;
      b = v[i];
      drive(1'b1, b ? hi1 : hi0);
      drive(1'b0, (i == 0) ? lo_gap : (b ? 20 : 40));
    end
  endtask

  task automatic send_pixel(input logic [23:0] v, input logic [IDX_W-1:0] idx,
                            input int lo_gap);
    sb.push_back('{pix: v, idx: idx});
    send_word(v, 24, 20, 40, lo_gap);
  endtask

  task automatic drain(input string tag);
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pixel"}, 32'(bus.Pixel), 32'd0);
    check({tag, "_valid"}, 32'(bus.PixelValid), 32'd0);
    check({tag, "_index"}, 32'(bus.PixelIndex), 32'd0);
    check({tag, "_frame_end"}, 32'(bus.FrameEnd), 32'd0);
    check({tag, "_error"}, 32'(bus.Error), 32'd0);
  endtask

  initial begin
    int fe0;
    int pv0;

    Reset   = 1'b0;
    bus.Din = 1'b0;
    repeat (4) @(negedge Clock);
    check_outputs_zero("reset");
    Reset = 1'b1;

    // 1: initial gap, then a single pixel
    drive(1'b0, 2500);
    fe0 = fe_count;
    pv0 = pv_count;
    send_pixel(24'hA5C30F, 0, 40);
    drain("t1");
    check("t1_valid_count", 32'(pv_count - pv0), 32'd1);
    check("t1_no_frame_end", 32'(fe_count - fe0), 32'd0);
    drive(1'b0, 2600);
    check("t1_frame_end", 32'(fe_count - fe0), 32'd1);

    // 2: three pixels, latch, then the next frame restarts at index 0
    fe0 = fe_count;
    send_pixel(24'h000001, 0, 40);
    send_pixel(24'hFFFFFF, 1, 40);
    send_pixel(24'h800000, 2, 2500);
    drive(1'b0, 10);
    drain("t2");
    check("t2_frame_end", 32'(fe_count - fe0), 32'd1);
    send_pixel(24'h123456, 0, 40);
    drain("t2b");

    // 3: 29/30-cycle highs and 2499/2500-cycle lows
    fe0 = fe_count;
    sb.push_back('{pix: 24'h5A3CC3, idx: 1});
    send_word(24'h5A3CC3, 24, 29, 30, 2499);
    drain("t3a");
    send_pixel(24'h0F0F0F, 2, 2500);
    drain("t3b");
    check("t3_gap2499", 32'(fe_count - fe0), 32'd0);
    send_pixel(24'h00FF00, 0, 40);
    drain("t3c");
    check("t3_gap2500", 32'(fe_count - fe0), 32'd1);
    check("t3_error", 32'(bus.Error), 32'd0);

    // 4: over-long high mid-pixel, recovery through a gap
    fe0 = fe_count;
    pv0 = pv_count;
    send_word(24'h000015, 5, 20, 40, 40);
    bus.Din = 1'b1;
    repeat (95) @(negedge Clock);
    check("t4_error_early", 32'(bus.Error), 32'd0);
    repeat (15) @(negedge Clock);
    check("t4_error_set", 32'(bus.Error), 32'd1);
    repeat (40) @(negedge Clock);
    drive(1'b0, 2600);
    check("t4_error_clear", 32'(bus.Error), 32'd0);
    check("t4_no_frame_end", 32'(fe_count - fe0), 32'd0);
    check("t4_no_valid", 32'(pv_count - pv0), 32'd0);
    send_pixel(24'hC0FFEE, 0, 40);
    drain("t4");

    // 5: partial pixel abandoned by a latch gap
    fe0 = fe_count;
    pv0 = pv_count;
    send_word(24'h000ABC, 12, 20, 40, 2500);
    drive(1'b0, 10);
    check("t5_frame_end", 32'(fe_count - fe0), 32'd1);
    check("t5_no_valid", 32'(pv_count - pv0), 32'd0);
    send_pixel(24'h13579B, 0, 40);
    drain("t5");

    // 6: reset after bit 10; data before the next gap is ignored
    send_word(24'h0003FF, 10, 20, 40, 40);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    check_outputs_zero("t6_reset");
    fe0 = fe_count;
    pv0 = pv_count;
    send_word(24'hFFFFFF, 24, 20, 40, 40);
    check("t6_ignored", 32'(pv_count - pv0), 32'd0);
    drive(1'b0, 2500);
    check("t6_no_frame_end", 32'(fe_count - fe0), 32'd0);
    send_pixel(24'h2468AC, 0, 40);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
